// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch stage and its consumers in decode.
package instr_fetch_pkg;

  typedef logic [31:0] word_addr_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam word_addr_t  DEFAULT_RESET_PC  = 32'h0000_0000;

  // Word addresses wrap naturally at 2^32.
  function automatic word_addr_t next_word_addr(input word_addr_t addr);
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > hold > load; no load also yields a bubble.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  word_addr_t  pc_i,
  output logic [31:0] instr_o,
  output word_addr_t  pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  word_addr_t  pc_q, pc_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc_d    = 32'd0;
      valid_d = 1'b0;
    end else if (hold_i) begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      pc_d    = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, runs the imem req/ready handshake and feeds the IF/ID register.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter word_addr_t  RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  word_addr_t  redirect_target,
  output logic        imem_req,
  output word_addr_t  imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output word_addr_t  pc_out,
  output logic        valid_out
);

  fetch_state_t state_q, state_d;
  word_addr_t   fetch_pc_q, fetch_pc_d;
  word_addr_t   pending_pc_q, pending_pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic         load_s;
  logic [31:0]  load_instr_s;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    skid_instr_d = skid_instr_q;
    load_s       = 1'b0;
    load_instr_s = imem_rdata;
    case (state_q)
      FETCH: begin
        load_s = imem_ready;
        if (imem_ready) begin
          if (redirect_valid) begin
            fetch_pc_d = redirect_target;
          end else if (stall) begin
            skid_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            fetch_pc_d = next_word_addr(fetch_pc_q);
          end
        end else if (redirect_valid) begin
          // Request stays up at the old address; its data is thrown away later.
          pending_pc_d = redirect_target;
          state_d      = DROP;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        load_s       = 1'b1;
        load_instr_s = skid_instr_q;
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          state_d    = FETCH;
        end else if (!stall) begin
          fetch_pc_d = next_word_addr(fetch_pc_q);
          state_d    = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        if (imem_ready) begin
          // A redirect arriving on the completing cycle is the newest target.
          fetch_pc_d = redirect_valid ? redirect_target : pending_pc_q;
          state_d    = FETCH;
        end else if (redirect_valid) begin
          pending_pc_d = redirect_target;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= 32'd0;
      skid_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign imem_req  = !reset && (state_q != HOLD);
  assign imem_addr = fetch_pc_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .flush_i(redirect_valid),
    .hold_i (stall),
    .load_i (load_s),
    .instr_i(load_instr_s),
    .pc_i   (next_word_addr(fetch_pc_q)),
    .instr_o(instr_out),
    .pc_o   (pc_out),
    .valid_o(valid_out)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a flag-based behavioural model, plus directed pins.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] SIG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0, imem_ready = 1'b0;
  logic [31:0] redirect_target = 32'd0, imem_rdata = 32'd0;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, pc_out;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;

  int tests = 0;
  int fails = 0;

  // Model state: current fetch address, a parked completed fetch, an outstanding fetch to discard.
  logic [31:0] m_pc = 32'd0, m_pending = 32'd0, m_parked_instr = 32'd0;
  bit          m_parked = 1'b0, m_discard = 1'b0;
  logic [31:0] e_instr = 32'd0, e_pc = 32'd0;
  bit          e_valid = 1'b0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_out(w_instr),
    .pc_out(w_pc), .valid_out(w_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bubble();
    e_instr = NOP;
    e_pc    = 32'd0;
    e_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs applied during that cycle.
  task automatic model_step();
    bit done;
    if (reset) begin
      m_pc = RPC; m_parked = 1'b0; m_discard = 1'b0;
      bubble();
    end else begin
      done = !m_parked && imem_ready;
      if (redirect_valid) bubble();
      else if (stall) begin end
      else if (m_parked) begin e_instr = m_parked_instr; e_pc = m_pc + 32'd1; e_valid = 1'b1; end
      else if (done && !m_discard) begin e_instr = imem_rdata; e_pc = m_pc + 32'd1; e_valid = 1'b1; end
      else bubble();

      if (m_parked) begin
        if (redirect_valid) begin m_pc = redirect_target; m_parked = 1'b0; end
        else if (!stall) begin m_pc = m_pc + 32'd1; m_parked = 1'b0; end
      end else if (m_discard) begin
        if (redirect_valid) m_pending = redirect_target;
        if (imem_ready) begin m_pc = m_pending; m_discard = 1'b0; end
      end else if (imem_ready) begin
        if (redirect_valid) m_pc = redirect_target;
        else if (stall) begin m_parked = 1'b1; m_parked_instr = imem_rdata; end
        else m_pc = m_pc + 32'd1;
      end else if (redirect_valid) begin
        m_discard = 1'b1; m_pending = redirect_target;
      end
    end
  endtask

  task automatic compare();
    check("imem_req", {31'd0, imem_req}, {31'd0, (!reset && !m_parked)});
    check("imem_addr", imem_addr, m_pc);
    check("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    check("instr_out", instr_out, e_instr);
    if (e_valid) check("pc_out", pc_out, e_pc);
  endtask

  task automatic run_cycle(input logic r, input logic st, input logic rv,
                           input logic [31:0] rt, input logic rdy);
    reset = r; stall = st; redirect_valid = rv; redirect_target = rt; imem_ready = rdy;
    imem_rdata = rdy ? (m_pc ^ SIG) : $urandom();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic r, st, rv, rdy;
    logic [31:0] rt;

    // Reset state, and the wrapping instance starting at the top of memory.
    run_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc", pc_out, 32'd0);
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFF);

    // Streaming with ready tied high.
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("first_instr", instr_out, 32'hA5A5_0000);
    check("first_pc", pc_out, 32'd1);
    check("first_valid", {31'd0, valid_out}, 32'd1);
    check("wrap_pc", w_pc, 32'd0);
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    check("wrap_next_addr", w_addr, 32'd0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("seq3_instr", instr_out, 32'hA5A5_0002);
    check("seq3_pc", pc_out, 32'd3);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("seq4_addr", imem_addr, 32'd4);

    // Stall while the fetch of address 4 completes.
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("hold_instr", instr_out, 32'hA5A5_0003);
    check("hold_pc", pc_out, 32'd4);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("release_instr", instr_out, 32'hA5A5_0004);
    check("release_pc", pc_out, 32'd5);
    check("release_addr", imem_addr, 32'd5);

    // Redirect while the request is outstanding, memory latency 2.
    run_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    check("drop_addr_held", imem_addr, 32'd5);
    check("drop_valid", {31'd0, valid_out}, 32'd0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("drop_target_addr", imem_addr, 32'h40);
    check("drop_discard_valid", {31'd0, valid_out}, 32'd0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("target_instr", instr_out, 32'hA5A5_0040);
    check("target_pc", pc_out, 32'h41);

    // Simultaneous stall and redirect.
    run_cycle(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
    check("stall_redir_valid", {31'd0, valid_out}, 32'd0);
    check("stall_redir_instr", instr_out, NOP);
    check("stall_redir_addr", imem_addr, 32'h100);

    // Reset in the middle of a discard.
    run_cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("midrst_addr", imem_addr, RPC);
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("midrst_instr", instr_out, 32'hA5A5_0000);
    check("midrst_pc", pc_out, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      rt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom();
      run_cycle(r, st, rv, rt, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
